// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer-width helper for the dual-clock FIFO and its read/write endpoints.
// Latency: none (declarations only); backpressure: not applicable.
package fifo_pkg;
    localparam int FIFO_DATA_W = 17;
    localparam int FIFO_RD_LAT = 1;

    // A one-entry structure still needs a one-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/stream_buf.sv
// Circular buffer with push/pop/flush and occupancy count; the head word is presented from a head-indexed read.
// Latency: push visible at head the next cycle; backpressure: the caller must not push when full, and pop is ignored when empty.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              pop_ok;
    logic              push_ok;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok  = pop && (count != '0) && !flush;
    assign push_ok = push && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push_ok) tail <= wrap_inc(tail);
            if (pop_ok)  head <= wrap_inc(head);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= push_data;
    end

    // Zero while empty keeps the output defined even though the RAM itself is never reset.
    assign head_data = (count != '0) ? mem[head] : '0;
endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO consumer: credit-limited read enables, in-flight tracking and re-presentation as a valid/ready stream.
// Latency: fifo_ren to m_valid is 2 cycles; backpressure: reads stop once buffered plus in-flight words fill the buffer, never from m_ready.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic [DATA_W-1:0]                fifo_rdata,
    output logic                             fifo_ren,
    input  logic                             en,
    input  logic                             flush,
    output logic                             m_valid,
    output logic [DATA_W-1:0]                m_data,
    input  logic                             m_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]                 rd_count
);
    localparam int LVL_W = $clog2(BUF_DEPTH + 1);

    logic             inflight;
    logic             push;
    logic             pop;
    logic [LVL_W-1:0] count;
    logic [LVL_W:0]   credit_used;

    // Words already requested from the FIFO hold a slot, so the buffer can never overflow.
    assign credit_used = {1'b0, count} + (LVL_W + 1)'(inflight);
    assign fifo_ren    = en && !fifo_empty && !flush && !rst &&
                         (credit_used < (LVL_W + 1)'(BUF_DEPTH));

    assign push    = inflight && !flush;
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    assign level   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_ren;
            if (pop) rd_count <= rd_count + CNT_W'(1);
        end
    end

    stream_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_rdata),
        .pop       (pop),
        .flush     (flush),
        .head_data (m_data),
        .count     (count)
    );
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed + randomized bench for fifo_rd_drain with a queue-based FIFO model and scoreboard.
module tb_fifo_rd_drain;
    import fifo_pkg::*;

    localparam int DW    = FIFO_DATA_W;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_ren;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [LW-1:0] level;
    logic [CW-1:0] rd_count;

    fifo_rd_drain #(.DATA_W(DW), .BUF_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .en         (en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .level      (level),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: fifo_q is the FIFO contents; exp_q holds every word read and not yet delivered (in-flight word last).
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q [$];
    logic          force_empty = 1'b0;
    int            inflight_m = 0;
    int            exp_cnt = 0;
    int            cyc = 0;
    int            n_ren, n_vld, n_del, first_vld, last_vld, first_ren, ren_cyc;
    logic [DW-1:0] first_word;
    logic [CW-1:0] base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_ren = 0; n_vld = 0; n_del = 0;
        first_vld = -1; last_vld = -1; first_ren = -1; ren_cyc = -1;
        first_word = '0;
    endtask

    task automatic tick();
        logic          exp_ren;
        logic          ren_s;
        logic [DW-1:0] nxt;
        int            held;
        nxt = '0;
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        @(negedge clk);
        held    = exp_q.size() - inflight_m;
        exp_ren = en && !fifo_empty && !flush && (exp_q.size() < DEPTH);
        ren_s   = fifo_ren;
        chk("fifo_ren", 32'(fifo_ren), 32'(exp_ren));
        chk("empty_guard", 32'(fifo_ren && fifo_empty), 32'(0));
        chk("level", 32'(level), 32'(held));
        chk("m_valid", 32'(m_valid), 32'(held != 0));
        if (m_valid && exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("rd_count", 32'(rd_count), 32'(exp_cnt));
        if (m_valid) begin
            n_vld++;
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_cnt = (exp_cnt + 1) % 65536;
            if (n_del == 0) first_word = m_data;
            n_del++;
        end
        if (flush) exp_q.delete();
        if (ren_s) begin
            nxt = (fifo_q.size() > 0) ? fifo_q.pop_front() : DW'($urandom);
            exp_q.push_back(nxt);
            n_ren++;
            if (first_ren < 0) first_ren = cyc;
            ren_cyc = cyc;
        end
        inflight_m = ren_s ? 1 : 0;
        @(posedge clk);
        #1;
        cyc++;
        fifo_rdata = ren_s ? nxt : DW'($urandom);
    endtask

    initial begin
        clr_stats();
        #1 rst = 1'b1;
        #1;
        chk("rst_ren", 32'(fifo_ren), 32'(0));
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_data", 32'(m_data), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_count", 32'(rd_count), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single word.
        en = 1'b1; m_ready = 1'b1; clr_stats();
        fifo_q.push_back(17'h1A5A5);
        repeat (6) tick();
        chk("single_ren_cnt", 32'(n_ren), 32'(1));
        chk("single_vld_cnt", 32'(n_vld), 32'(1));
        chk("single_latency", 32'(first_vld - ren_cyc), 32'(2));
        chk("single_data", 32'(first_word), 32'h1A5A5);
        chk("single_rd_count", 32'(rd_count), 32'(1));

        // Streaming 0..99.
        clr_stats(); base = rd_count;
        for (int i = 0; i < 100; i++) fifo_q.push_back(DW'(i));
        repeat (110) tick();
        chk("stream_fill", 32'(first_vld - first_ren), 32'(2));
        chk("stream_vld_cnt", 32'(n_vld), 32'(100));
        chk("stream_gapless", 32'(last_vld - first_vld), 32'(99));
        chk("stream_rd_count", 32'(CW'(rd_count - base)), 32'(100));

        // Backpressure with 10 words available.
        clr_stats(); m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(i));
        repeat (10) tick();
        chk("bp_ren_cnt", 32'(n_ren), 32'(DEPTH));
        chk("bp_level", 32'(level), 32'(DEPTH));
        chk("bp_data", 32'(m_data), 32'(0));
        m_ready = 1'b1; clr_stats();
        repeat (20) tick();
        chk("bp_delivered", 32'(n_del), 32'(10));
        chk("bp_gapless", 32'(last_vld - first_vld), 32'(9));

        // Random empty flag, enable and ready.
        clr_stats();
        for (int i = 0; i < 200; i++) fifo_q.push_back(DW'($urandom));
        for (int t = 0; t < 3000 && (fifo_q.size() > 0 || exp_q.size() > 0); t++) begin
            force_empty = ($urandom_range(0, 2) == 0);
            m_ready     = ($urandom_range(0, 3) != 0);
            en          = ($urandom_range(0, 9) != 0);
            tick();
        end
        force_empty = 1'b0; en = 1'b1; m_ready = 1'b1;
        chk("rand_delivered", 32'(n_del), 32'(200));
        chk("rand_drained", 32'(exp_q.size()), 32'(0));

        // Flush with three buffered and one in flight.
        clr_stats(); m_ready = 1'b0;
        fifo_q.push_back(17'h00011); fifo_q.push_back(17'h00022);
        fifo_q.push_back(17'h00033); fifo_q.push_back(17'h00044);
        fifo_q.push_back(17'h00077);
        repeat (4) tick();
        chk("flush_pre_level", 32'(level), 32'(3));
        chk("flush_pre_reads", 32'(n_ren), 32'(4));
        base = rd_count;
        flush = 1'b1;
        tick();
        flush = 1'b0; m_ready = 1'b1;
        chk("flush_valid", 32'(m_valid), 32'(0));
        chk("flush_level", 32'(level), 32'(0));
        chk("flush_rd_count", 32'(rd_count), 32'(base));
        repeat (8) tick();
        chk("flush_first_word", 32'(first_word), 32'h00077);
        chk("flush_delivered", 32'(n_del), 32'(1));

        // Asynchronous reset mid-stream with two words buffered.
        clr_stats(); m_ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(17'h00100 + i));
        repeat (3) tick();
        chk("mid_pre_level", 32'(level), 32'(2));
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_ren", 32'(fifo_ren), 32'(0));
        chk("mid_rst_valid", 32'(m_valid), 32'(0));
        chk("mid_rst_level", 32'(level), 32'(0));
        chk("mid_rst_count", 32'(rd_count), 32'(0));
        fifo_q.delete(); exp_q.delete();
        inflight_m = 0; exp_cnt = 0;
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        clr_stats(); m_ready = 1'b1;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(17'h1F0F0 + i));
        repeat (14) tick();
        chk("post_rst_delivered", 32'(n_del), 32'(8));
        chk("post_rst_first", 32'(first_word), 32'h1F0F0);
        chk("post_rst_count", 32'(rd_count), 32'(8));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
